// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM state encoding
// and the bit positions of the per-stage enable and flush vectors.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALT    = 2'd3
    } pctl_state_e;

    localparam int NUM_STAGES = 4;
    localparam int NUM_FLUSH  = 3;

    // Enable bit i gates the register in front of stage i+1; flush bit i clears the same register.
    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: turns hazard, memory-handshake and halt requests
// into per-stage enables/flushes, with MEMWAIT timeout and DRAIN/HALT handling.
module pipeline_ctrl #(
    parameter int TIMEOUT   = 16,
    parameter int DRAIN_CYC = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_use,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             en_if,
    output logic             en_id,
    output logic             en_ex,
    output logic             en_mem,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             halted,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import pipe_ctrl_pkg::*;

    localparam int WAIT_W  = $clog2(TIMEOUT);
    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

    pctl_state_e               state_d, state_q;
    logic [WAIT_W-1:0]         wait_cnt_d, wait_cnt_q;
    logic [DRAIN_W-1:0]        drain_cnt_d, drain_cnt_q;
    logic                      err_d, err_q;
    logic [NUM_STAGES-1:0]     en_vec;
    logic [NUM_FLUSH-1:0]      flush_vec;
    logic                      mem_stall;
    logic                      stall_inc;
    logic                      flush_inc;

    assign mem_stall = mem_req && !mem_ready;

    // Enables and flushes react in the same cycle as their cause; only the sequencing state is registered.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        en_vec      = '0;
        flush_vec   = '0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        state_d    = MEMWAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end else if (branch_taken) begin
                        en_vec    = '1;
                        flush_vec = '1;
                    end else if (ld_use) begin
                        en_vec[STAGE_EX]    = 1'b1;
                        en_vec[STAGE_MEM]   = 1'b1;
                        flush_vec[STAGE_ID] = 1'b1;
                    end else if (halt_req) begin
                        en_vec           = '1;
                        en_vec[STAGE_IF] = 1'b0;
                        state_d          = DRAIN;
                        drain_cnt_d      = DRAIN_W'(1);
                    end else begin
                        en_vec = '1;
                    end
                end
                MEMWAIT: begin
                    en_vec = {NUM_STAGES{mem_ready}};
                    if (mem_ready) begin
                        state_d = RUN;
                    end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    flush_vec[STAGE_IF] = 1'b1;
                    if (!mem_stall) begin
                        en_vec           = '1;
                        en_vec[STAGE_IF] = 1'b0;
                        if (drain_cnt_q == DRAIN_W'(DRAIN_CYC)) begin
                            state_d = HALT;
                        end else begin
                            drain_cnt_d = drain_cnt_q + 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (resume && !err_q) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
        end
    end

    assign en_if       = en_vec[STAGE_IF];
    assign en_id       = en_vec[STAGE_ID];
    assign en_ex       = en_vec[STAGE_EX];
    assign en_mem      = en_vec[STAGE_MEM];
    assign flush_ifid  = flush_vec[STAGE_IF];
    assign flush_idex  = flush_vec[STAGE_ID];
    assign flush_exmem = flush_vec[STAGE_EX];
    assign halted      = (state_q == HALT);
    assign err_timeout = err_q;

    // A frozen fetch while halted is intentional, so it is not charged as a stall.
    assign stall_inc = !en_vec[STAGE_IF] && (state_q != HALT) && !rst;
    assign flush_inc = flush_vec[STAGE_EX];

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .q   (flush_cnt)
    );

endmodule
